// File: rtl/calendar_pkg.sv
// calendar_pkg
// Shared definitions for the date sequencer: the set-mode FSM state
// encoding, field widths, calendar limits and month-length constants.
package calendar_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 7;

  // The state encoding doubles as the set_field output seen by the display.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_DAY   = 2'b01,
    SET_MONTH = 2'b10,
    SET_YEAR  = 2'b11
  } state_t;

  localparam logic [DAY_W-1:0]   DAY_FIRST     = 5'd1;
  localparam logic [MONTH_W-1:0] MONTH_FIRST   = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_LAST    = 4'd12;
  localparam logic [YEAR_W-1:0]  YEAR_FIRST    = 7'd0;
  localparam logic [YEAR_W-1:0]  YEAR_LAST     = 7'd99;

  localparam logic [DAY_W-1:0]   DAYS_LONG     = 5'd31;
  localparam logic [DAY_W-1:0]   DAYS_SHORT    = 5'd30;
  localparam logic [DAY_W-1:0]   DAYS_FEB      = 5'd28;
  localparam logic [DAY_W-1:0]   DAYS_FEB_LEAP = 5'd29;

endpackage

// File: rtl/days_in_month.sv
// days_in_month
// Combinational month-length lookup.
// Ports:
//   month   - month 1..12
//   year    - year offset 0..99 (2000..2099)
//   max_day - number of days in that month of that year
module days_in_month
  import calendar_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   max_day
);

  // Every multiple of four in 2000..2099 is a leap year, including 2000
  // itself, so the two low year bits are enough to decide February.
  always_comb begin
    max_day = DAYS_LONG;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: max_day = DAYS_SHORT;
      4'd2:                    max_day = (year[1:0] == 2'b00) ? DAYS_FEB_LEAP : DAYS_FEB;
      default:                 max_day = DAYS_LONG;
    endcase
  end

endmodule

// File: rtl/date_sequencer.sv
// date_sequencer
// Calendar date register with a button-driven set mode.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   day_tick     - midnight pulse; advances the date while in RUN
//   btn_set      - steps RUN -> SET_DAY -> SET_MONTH -> SET_YEAR -> RUN
//   btn_inc      - increments the field selected in set mode
//   day/month/year - current date (year is an offset from 2000)
//   set_field    - current FSM state, used for display blinking
//   month_pulse  - one-cycle pulse on a run-mode month rollover
//   year_pulse   - one-cycle pulse on a run-mode year rollover
module date_sequencer
  import calendar_pkg::*;
#(
  parameter int unsigned RESET_YEAR = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               day_tick,
  input  logic               btn_set,
  input  logic               btn_inc,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic [1:0]         set_field,
  output logic               month_pulse,
  output logic               year_pulse
);

  // An out-of-range reset year would leave the calendar in a state it can
  // never legally reach, so refuse to elaborate.
  if (RESET_YEAR > 99) begin : g_bad_reset_year
    $error("date_sequencer: RESET_YEAR must be 0..99");
  end

  localparam logic [YEAR_W-1:0] RESET_YEAR_V = YEAR_W'(RESET_YEAR);

  state_t             state;
  logic [DAY_W-1:0]   cur_max;
  logic [DAY_W-1:0]   probe_max;
  logic [MONTH_W-1:0] inc_month;
  logic [YEAR_W-1:0]  inc_year;
  logic [MONTH_W-1:0] probe_month;
  logic [YEAR_W-1:0]  probe_year;
  logic [DAY_W-1:0]   clamp_day;

  // Length of the month currently held, used by the run path and SET_DAY.
  days_in_month u_cur_dim (
    .month   (month),
    .year    (year),
    .max_day (cur_max)
  );

  // Length of the month we would land in after a set-mode month or year
  // increment, so the day can be clamped in the same cycle as the change.
  days_in_month u_probe_dim (
    .month   (probe_month),
    .year    (probe_year),
    .max_day (probe_max)
  );

  // Wrapped increments of month and year, and the candidate date that a
  // set-mode increment would produce. In SET_YEAR only the year moves; in
  // any other state the probe looks at the next month.
  always_comb begin
    inc_month   = (month == MONTH_LAST) ? MONTH_FIRST : month + 4'd1;
    inc_year    = (year == YEAR_LAST) ? YEAR_FIRST : year + 7'd1;
    probe_month = inc_month;
    probe_year  = year;
    if (state == SET_YEAR) begin
      probe_month = month;
      probe_year  = inc_year;
    end
    clamp_day = (day > probe_max) ? probe_max : day;
  end

  assign set_field = state;

  // Single FSM and datapath register. btn_set always takes priority over
  // btn_inc. In RUN a coincident day_tick is still applied while the state
  // moves to SET_DAY. Pulses are cleared every cycle unless a run-mode
  // rollover sets them, which keeps them to one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      day         <= DAY_FIRST;
      month       <= MONTH_FIRST;
      year        <= RESET_YEAR_V;
      month_pulse <= 1'b0;
      year_pulse  <= 1'b0;
    end else begin
      month_pulse <= 1'b0;
      year_pulse  <= 1'b0;
      case (state)
        RUN: begin
          if (day_tick) begin
            if (day < cur_max) begin
              day <= day + 5'd1;
            end else begin
              day         <= DAY_FIRST;
              month_pulse <= 1'b1;
              month       <= inc_month;
              if (month == MONTH_LAST) begin
                year_pulse <= 1'b1;
                year       <= inc_year;
              end
            end
          end
          if (btn_set) state <= SET_DAY;
        end
        SET_DAY: begin
          if (btn_set) begin
            state <= SET_MONTH;
          end else if (btn_inc) begin
            day <= (day >= cur_max) ? DAY_FIRST : day + 5'd1;
          end
        end
        SET_MONTH: begin
          if (btn_set) begin
            state <= SET_YEAR;
          end else if (btn_inc) begin
            month <= inc_month;
            day   <= clamp_day;
          end
        end
        SET_YEAR: begin
          if (btn_set) begin
            state <= RUN;
          end else if (btn_inc) begin
            year <= inc_year;
            day  <= clamp_day;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_date_sequencer.sv
// tb_date_sequencer
// Directed testbench for date_sequencer with hand-computed expectations.
module tb_date_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [1:0] set_field;
  logic       month_pulse;
  logic       year_pulse;

  int checkCount = 0;
  int errorCount = 0;

  date_sequencer #(.RESET_YEAR(18)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .day_tick    (day_tick),
    .btn_set     (btn_set),
    .btn_inc     (btn_inc),
    .day         (day),
    .month       (month),
    .year        (year),
    .set_field   (set_field),
    .month_pulse (month_pulse),
    .year_pulse  (year_pulse)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against an expected date/state/pulse tuple.
  task automatic checkDate(input string tag, input int d, input int m, input int y,
                           input int sf, input int mp, input int yp);
    checkOutput({tag, ".day"}, day, d);
    checkOutput({tag, ".month"}, month, m);
    checkOutput({tag, ".year"}, year, y);
    checkOutput({tag, ".set_field"}, set_field, sf);
    checkOutput({tag, ".month_pulse"}, month_pulse, mp);
    checkOutput({tag, ".year_pulse"}, year_pulse, yp);
  endtask

  // Drive one cycle of inputs from the falling edge, let the rising edge
  // take them, and leave the bench #1 after that edge for sampling.
  task automatic applyStimulus(input logic s, input logic i, input logic t);
    @(negedge clk);
    btn_set  = s;
    btn_inc  = i;
    day_tick = t;
    @(posedge clk);
    #1;
    btn_set  = 1'b0;
    btn_inc  = 1'b0;
    day_tick = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load a date through the buttons: from reset (1/1/18) set month and
  // year with day still 1 so nothing clamps, then set the day.
  task automatic setDate(input int d, input int m, input int y);
    doReset();
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (m - 1) applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    repeat ((y + 100 - 18) % 100) applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (d - 1) applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(1, 0, 0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkDate("reset", 1, 1, 18, 0, 0, 0);
    rst_n = 1'b1;

    // First edge after release acts normally.
    applyStimulus(1, 0, 0);
    checkDate("first_edge", 1, 1, 18, 1, 0, 0);

    // End-of-century rollover and single-cycle pulses.
    setDate(31, 12, 99);
    checkDate("load_31_12_99", 31, 12, 99, 0, 0, 0);
    applyStimulus(0, 0, 1);
    checkDate("year_roll", 1, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0);
    checkDate("year_roll_next", 1, 1, 0, 0, 0, 0);

    // Leap and non-leap February.
    setDate(28, 2, 20);
    applyStimulus(0, 0, 1);
    checkDate("leap_28_2_20", 29, 2, 20, 0, 0, 0);
    applyStimulus(0, 0, 1);
    checkDate("leap_29_2_20", 1, 3, 20, 0, 1, 0);
    setDate(28, 2, 21);
    applyStimulus(0, 0, 1);
    checkDate("nonleap_28_2_21", 1, 3, 21, 0, 1, 0);

    // Thirty-day month rollover, then btn_inc ignored in RUN.
    setDate(30, 4, 18);
    applyStimulus(0, 0, 1);
    checkDate("april_roll", 1, 5, 18, 0, 1, 0);
    applyStimulus(0, 1, 0);
    checkDate("run_inc_ignored", 1, 5, 18, 0, 0, 0);

    // Tick and set together in RUN: tick applied and SET_DAY entered.
    applyStimulus(1, 0, 1);
    checkDate("tick_and_set", 2, 5, 18, 1, 0, 0);

    // Set-month clamp from 31 January.
    setDate(31, 1, 18);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkDate("month_clamp", 28, 2, 18, 2, 0, 0);

    // Set-year clamp 29/2/20 -> year 21.
    setDate(29, 2, 20);
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkDate("year_clamp", 28, 2, 21, 3, 0, 0);

    // Set-mode wraps do not pulse.
    setDate(15, 12, 99);
    repeat (2) applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkDate("set_month_wrap", 15, 1, 99, 2, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkDate("set_year_wrap", 15, 1, 0, 3, 0, 0);

    // SET_DAY wraps at the month length; tick ignored; set beats inc.
    setDate(30, 4, 18);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkDate("set_day_wrap", 1, 4, 18, 1, 0, 0);
    applyStimulus(0, 0, 1);
    checkDate("set_tick_ignored", 1, 4, 18, 1, 0, 0);
    applyStimulus(1, 1, 0);
    checkDate("set_beats_inc", 1, 4, 18, 2, 0, 0);

    // Asynchronous reset in the middle of a cycle while in SET_YEAR.
    setDate(1, 1, 50);
    repeat (3) applyStimulus(1, 0, 0);
    checkDate("in_set_year", 1, 1, 50, 3, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkDate("async_reset", 1, 1, 18, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1);
    checkDate("after_reset_tick", 2, 1, 18, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/date_sequencer.md
DATE_SEQUENCER -- requirements
Module: date_sequencer

Interface
REQ-001 Parameter RESET_YEAR, default 18, year value (0..99, meaning 2000..2099) loaded at reset.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 day_tick  input  1  one-cycle pulse from the time-of-day counter at 23:59:59 -> 00:00:00.
REQ-005 btn_set  input  1  one-cycle pulse, already debounced and synchronous; advances set-mode field.
REQ-006 btn_inc  input  1  one-cycle pulse, already debounced and synchronous; increments the selected field.
REQ-007 day  output  5  current day of month, 1..31.
REQ-008 month  output  4  current month, 1..12.
REQ-009 year  output  7  current year offset, 0..99.
REQ-010 set_field  output  2  00 = RUN, 01 = day, 10 = month, 11 = year; drives display blinking.
REQ-011 month_pulse  output  1  one-cycle pulse on a run-mode month rollover.
REQ-012 year_pulse  output  1  one-cycle pulse on a run-mode year rollover.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from input to output.
REQ-014 FSM states SHALL be RUN, SET_DAY, SET_MONTH and SET_YEAR; set_field SHALL equal the state encoding.
REQ-015 On btn_set, the FSM SHALL move RUN->SET_DAY->SET_MONTH->SET_YEAR->RUN, one step per pulse.
REQ-016 In RUN, day_tick SHALL produce the updated date one cycle later (latency 1).
REQ-017 Run increment: if day < max_day(month, year), day+1; otherwise day=1 and the month advances.
REQ-018 Month advance: if month < 12, month+1 and month_pulse=1; if month == 12, month=1, year advances, and both month_pulse and year_pulse=1.
REQ-019 Year advance SHALL wrap 99->0.
REQ-020 max_day SHALL be 31 for months 1,3,5,7,8,10,12 and 30 for months 4,6,9,11.
REQ-021 For month 2, max_day SHALL be 29 when year[1:0]==0 and 28 otherwise; year 0 (2000) is a leap year.
REQ-022 In SET_DAY, btn_inc SHALL advance day by 1, wrapping max_day->1, with no effect on month or year.
REQ-023 In SET_MONTH, btn_inc SHALL advance month by 1, wrapping 12->1.
REQ-024 In SET_YEAR, btn_inc SHALL advance year by 1, wrapping 99->0.
REQ-025 When a month or year change makes the current day exceed the new max_day, day SHALL clamp to the new max_day in the same cycle.
REQ-026 Set-mode changes SHALL NOT assert month_pulse or year_pulse.
REQ-027 day_tick SHALL be ignored in all SET_* states.
REQ-028 btn_inc in RUN SHALL be ignored.
REQ-029 If btn_set and btn_inc arrive in the same cycle, btn_set SHALL win and btn_inc SHALL be dropped.
REQ-030 Simultaneous day_tick and btn_set in RUN: the tick SHALL be applied and the FSM SHALL enter SET_DAY in the same cycle.
REQ-031 month_pulse and year_pulse SHALL never stay high for more than one cycle.

Reset
REQ-032 While rst_n=0, the outputs SHALL be: day=1, month=1, year=RESET_YEAR, state RUN, set_field=00, pulses 0.
REQ-033 Reset asserted mid-set or mid-rollover SHALL abort immediately, leaving no partial update after release.
REQ-034 The first edge after rst_n deasserts SHALL act on its inputs normally.

Structure
REQ-035 A shared package calendar_pkg SHALL hold the FSM state enum, the field widths and the month-length constants (31/30/28/29).
REQ-036 A combinational sub-module days_in_month (month, year -> max_day) SHALL be instantiated, shared by the run and set paths.
REQ-037 RESET_YEAR SHALL be checked to be <= 99.

Verification
REQ-038 Date 31/12/99, day_tick -> after 1 cycle 1/1/00, with month_pulse=1 and year_pulse=1 for exactly one cycle.
REQ-039 Date 28/2/20, then 28/2/21, each followed by day_tick -> 29/2/20 (leap year) and 1/3/21 with month_pulse=1.
REQ-040 Date 31/1/18: btn_set x2 (SET_MONTH), then btn_inc -> month=2 and day clamped to 28, with no pulses.
REQ-041 SET_DAY with day_tick, and btn_inc+btn_set in the same cycle -> date unchanged and state SET_MONTH.
REQ-042 rst_n pulled low asynchronously mid-cycle while in SET_YEAR with year=50 -> immediate 1/1/18, RUN, set_field=00.
REQ-043 Date 30/4/18, day_tick -> 1/5/18 with month_pulse=1 and year_pulse=0.
